branch_predictor: RTL
=====================

# branch_predictor

Fetch-side direction predictor and branch target buffer: the predicting end of the branch-resolution path driven by `fu_branch`. It predicts taken/target combinationally for the fetch PC. It is trained by the resolved outcome that `fu_branch` reports. It raises a registered mispredict/redirect one cycle after a resolution disagrees with the prediction that travelled with that branch.

## Interface
Parameters:
- `ENTRIES`, 16: BTB/counter entries; power of two, ≥ 2.
- `IDX_W`, $clog2(ENTRIES): index width; index = `pc[IDX_W+1:2]`, tag = `pc[31:IDX_W+2]`.

Ports (clock and reset first). One clock; reset is asynchronous and active-low (`CLK`, `nRST`).
- `CLK`  in  1  clock; all state updates on the rising edge.
- `nRST`  in  1  asynchronous active-low reset.
- `fetch_valid`  in  1  fetch lookup request.
- `fetch_pc`  in  32  fetch PC, word aligned.
- `pred_taken`  out  1  predicted taken.
- `pred_target`  out  32  predicted target; equals `fetch_pc+4` when not predicted taken.
- `upd_valid`  in  1  resolution from `fu_branch`; single-cycle pulse per branch.
- `upd_pc`  in  32  PC of the resolved branch.
- `upd_taken`  in  1  actual outcome.
- `upd_target`  in  32  actual target (`current_pc + imm`).
- `upd_pred_taken`  in  1  prediction made at fetch for this branch.
- `upd_pred_target`  in  32  target predicted at fetch for this branch.
- `mispredict`  out  1  registered one-cycle pulse.
- `redirect_pc`  out  32  registered correct next PC; meaningful only when `mispredict`=1.

## Operation
- Entry state: `valid`, `tag`, `target[31:0]`, `cnt[1:0]` (2-bit saturating counter).
- Lookup is combinational on registered table state.
  - hit = `fetch_valid` & `valid[idx]` & tag match.
  - `pred_taken` = hit & `cnt[idx][1]`.
  - `pred_target` = `pred_taken` ? `target[idx]` : `fetch_pc+4` (32-bit wrap).
- Update, on the edge where `upd_valid`=1, indexed by `upd_pc`:
  - Hit, taken: `cnt` saturating increment (max 2'b11); `target` ← `upd_target`.
  - Hit, not taken: `cnt` saturating decrement (min 2'b00); `target` unchanged.
  - Miss, taken: allocate/replace; `valid`=1, `tag`, `target` ← `upd_target`, `cnt`=2'b10.
  - Miss, not taken: no table change.
- Mispredict condition:
  - `upd_taken` ≠ `upd_pred_taken`, or
  - both taken and `upd_target` ≠ `upd_pred_target`.
- Redirect value: `redirect_pc` = `upd_taken` ? `upd_target` : `upd_pc+4`.
- With `upd_valid`=0: `mispredict` ← 0 and `redirect_pc` holds its value.

## Timing
- Reset (asynchronous): all `valid`=0, all `cnt`=2'b01, all `target`=0, `mispredict`=0, `redirect_pc`=0. Consequence: `pred_taken`=0 and `pred_target`=`fetch_pc+4`.
- Prediction latency: 0 cycles (combinational).
- Training latency: an update is visible to lookups from the cycle after the `upd_valid` edge.
- Mispredict latency: 1 cycle after the `upd_valid` cycle, high for exactly one cycle per offending update.
- Same-index lookup and update in one cycle: the lookup sees pre-update contents. There is no bypass.
- Back-to-back updates (one per cycle) are supported. A second update to the same entry sees the first one's result.
- Reset asserted mid-operation clears the table and any pending `mispredict` immediately.

## Configuration
- `BPRED_STATS_EN` defined:
  - Adds outputs `stat_branches` (32) and `stat_mispredicts` (32).
  - Counters increment on each `upd_valid` and on each mispredict condition respectively.
  - Both wrap at 2^32 and reset to 0.
- `BPRED_STATS_EN` undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- After reset, `fetch_pc`=0x100, `fetch_valid`=1 -> `pred_taken`=0, `pred_target`=0x104.
- Update `upd_pc`=0x100, taken, `upd_target`=0x164, `upd_pred_taken`=0 -> next cycle `mispredict`=1, `redirect_pc`=0x164. Lookup 0x100 then gives `pred_taken`=1, `pred_target`=0x164 (`cnt`=2'b10).
- Three taken updates, then two not-taken updates at 0x100 -> `cnt` saturates at 2'b11 then reaches 2'b01. The lookup ends with `pred_taken`=0. A not-taken update with `upd_pred_taken`=1 gives `redirect_pc`=0x104.
- Aliasing: train 0x100 taken, then taken update at 0x100+4·`ENTRIES` with target 0x200 -> the entry is replaced. Lookup of 0x100 misses; lookup of the alias predicts 0x200.
- Target mismatch: both taken, `upd_pred_target`=0x164, `upd_target`=0x180 -> `mispredict`=1, `redirect_pc`=0x180. The entry target is updated to 0x180.
- Same-cycle lookup and update at 0x100 -> the lookup returns old values. Assert `nRST` low mid-sequence -> `mispredict`=0 immediately and the table is cleared. Under `BPRED_STATS_EN`, the counters match the number of updates and mispredicts issued.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-side 2-bit direction predictor with BTB and registered mispredict/redirect.
// Optional performance counters are compiled in with `define BPRED_STATS_EN.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc
`ifdef BPRED_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int TAG_W = 30 - IDX_W;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];
    logic [1:0]        cnt_q    [ENTRIES];

    logic              mispredict_q;
    logic [31:0]       redirect_q;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // Word-offset bits of both PCs are never used for indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

    logic [IDX_W-1:0] fidx;
    logic [TAG_W-1:0] ftag;
    logic             fhit;

    assign fidx        = fetch_pc[IDX_W+1:2];
    assign ftag        = fetch_pc[31:IDX_W+2];
    assign fhit        = fetch_valid && valid_q[fidx] && (tag_q[fidx] == ftag);
    assign pred_taken  = fhit && cnt_q[fidx][1];
    assign pred_target = pred_taken ? target_q[fidx] : fetch_pc + 32'd4;

    logic [IDX_W-1:0] uidx;
    logic [TAG_W-1:0] utag;
    logic             uhit;
    logic             wr_en;
    logic             valid_d;
    logic [TAG_W-1:0] tag_d;
    logic [31:0]      target_d;
    logic [1:0]       cnt_d;
    logic             mis_cond;
    logic [31:0]      redirect_d;

    assign uidx = upd_pc[IDX_W+1:2];
    assign utag = upd_pc[31:IDX_W+2];
    assign uhit = valid_q[uidx] && (tag_q[uidx] == utag);

    always_comb begin
        wr_en    = 1'b0;
        valid_d  = valid_q[uidx];
        tag_d    = tag_q[uidx];
        target_d = target_q[uidx];
        cnt_d    = cnt_q[uidx];
        if (upd_valid) begin
            if (uhit) begin
                wr_en = 1'b1;
                if (upd_taken) begin
                    cnt_d    = sat_inc(cnt_q[uidx]);
                    target_d = upd_target;
                end else begin
                    cnt_d = sat_dec(cnt_q[uidx]);
                end
            end else if (upd_taken) begin
                // Taken miss allocates (or evicts the aliasing branch) weakly taken.
                wr_en    = 1'b1;
                valid_d  = 1'b1;
                tag_d    = utag;
                target_d = upd_target;
                cnt_d    = 2'b10;
            end
        end
    end

    assign mis_cond   = (upd_taken != upd_pred_taken) ||
                        (upd_taken && upd_pred_taken && (upd_target != upd_pred_target));
    assign redirect_d = upd_taken ? upd_target : upd_pc + 32'd4;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= 2'b01;
            end
        end else if (wr_en) begin
            valid_q[uidx]  <= valid_d;
            tag_q[uidx]    <= tag_d;
            target_q[uidx] <= target_d;
            cnt_q[uidx]    <= cnt_d;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
        end else begin
            mispredict_q <= upd_valid && mis_cond;
            if (upd_valid) begin
                redirect_q <= redirect_d;
            end
        end
    end

    assign mispredict  = mispredict_q;
    assign redirect_pc = redirect_q;

`ifdef BPRED_STATS_EN
    logic [31:0] branches_q;
    logic [31:0] mispredicts_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else if (upd_valid) begin
            branches_q <= branches_q + 32'd1;
            if (mis_cond) begin
                mispredicts_q <= mispredicts_q + 32'd1;
            end
        end
    end

    assign stat_branches    = branches_q;
    assign stat_mispredicts = mispredicts_q;
`endif

endmodule
